// File: rtl/iic_mst.sv
// iic_mst -- byte-level I2C master engine.
// Executes one bus primitive per command (START, WRDATA, RDDATA, STOP, PRE_START)
// on open-drain SCL/SDA lines. SCL runs with a quarter period of
// Q = SYS_CLOCK/(4*IIC_CLOCK) system clocks and honours clock stretching.
// Ports:
//   i_SysClock      system clock, rising edge
//   i_ResetN        synchronous active-low reset
//   i_CmdValid      command strobe, taken only while o_Done is high
//   i_Cmd           1=START 2=WRDATA 3=RDDATA 4=STOP 5=PRE_START, others no-op
//   i_TxByte        byte to send on WRDATA
//   i_SetAck        level driven on the 9th bit of RDDATA (0=ACK)
//   o_RxByte        byte received by RDDATA, MSB first
//   o_GetAck        SDA sampled on the 9th bit of WRDATA (0=ACK)
//   o_Done          high when idle / command finished
//   io_SCL, io_SDA  open-drain bus lines (drive 0 or release)
module iic_mst #(
  parameter int SYS_CLOCK = 50000000,
  parameter int IIC_CLOCK = 100000
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_CmdValid,
  input  logic [3:0] i_Cmd,
  input  logic [7:0] i_TxByte,
  output logic [7:0] o_RxByte,
  output logic       o_Done,
  inout  wire        io_SCL,
  inout  wire        io_SDA,
  output logic       o_GetAck,
  input  logic       i_SetAck
);

  localparam int QRAW = SYS_CLOCK / (4 * IIC_CLOCK);
  localparam int QV   = (QRAW < 1) ? 1 : QRAW;
  localparam int QW   = (QV > 1) ? $clog2(QV) : 1;
  localparam logic [QW-1:0] QEND = QW'(QV - 1);

  localparam logic [3:0] CMD_START    = 4'd1;
  localparam logic [3:0] CMD_WRDATA   = 4'd2;
  localparam logic [3:0] CMD_RDDATA   = 4'd3;
  localparam logic [3:0] CMD_STOP     = 4'd4;
  localparam logic [3:0] CMD_PRESTART = 4'd5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WRITE_BIT = 3'd2,
    READ_BIT  = 3'd3,
    ACK_BIT   = 3'd4,
    STOP      = 3'd5,
    PRE_START = 3'd6,
    DONE      = 3'd7
  } state_e;

  state_e          state_r, stateNext_s;
  logic [2:0]      phase_r, lastPh_s;
  logic [QW-1:0]   qCnt_r;
  logic [2:0]      bitCnt_r;
  logic [7:0]      txByte_r, rxByte_r;
  logic            setAck_r, isRead_r, getAck_r, done_r;
  logic            sclRel_r, sdaRel_r, sclRelNext_s, sdaRelNext_s, doneNext_s;
  logic [1:0]      sclSync_r, sdaSync_r;
  logic            sclHigh_s, sdaIn_s, waitHigh_s, active_s, tick_s, lastTick_s, accept_s;

  // Open-drain: only ever pull low, otherwise leave the line to the pull-up.
  assign io_SCL = sclRel_r ? 1'bz : 1'b0;
  assign io_SDA = sdaRel_r ? 1'bz : 1'b0;

  assign o_RxByte = rxByte_r;
  assign o_GetAck = getAck_r;
  assign o_Done   = done_r;

  assign sclHigh_s  = sclSync_r[1];
  assign sdaIn_s    = sdaSync_r[1];
  assign active_s   = (state_r != IDLE) && (state_r != DONE);
  // A quarter only completes in a wait phase once SCL is really high (stretching).
  assign tick_s     = active_s && (qCnt_r == QEND) && (!waitHigh_s || sclHigh_s);
  assign lastTick_s = tick_s && (phase_r == lastPh_s);
  assign accept_s   = (state_r == IDLE) && i_CmdValid;

  // Two-flop synchronizers on the bus lines.
  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      sclSync_r <= 2'b11;
      sdaSync_r <= 2'b11;
    end else begin
      sclSync_r <= {sclSync_r[0], io_SCL};
      sdaSync_r <= {sdaSync_r[0], io_SDA};
    end
  end

  // Per-state phase count, and the phase in which SCL has been released.
  always_comb begin
    lastPh_s   = 3'd0;
    waitHigh_s = 1'b0;
    case (state_r)
      START:               begin lastPh_s = 3'd3; waitHigh_s = (phase_r == 3'd1); end
      WRITE_BIT, READ_BIT: begin lastPh_s = 3'd3; waitHigh_s = (phase_r == 3'd2); end
      ACK_BIT:             begin lastPh_s = 3'd4; waitHigh_s = (phase_r == 3'd2); end
      STOP:                begin lastPh_s = 3'd2; waitHigh_s = (phase_r == 3'd1); end
      PRE_START:           begin lastPh_s = 3'd1; waitHigh_s = (phase_r == 3'd1); end
      default:             begin lastPh_s = 3'd0; waitHigh_s = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_CmdValid) begin
          case (i_Cmd)
            CMD_START:    stateNext_s = START;
            CMD_WRDATA:   stateNext_s = WRITE_BIT;
            CMD_RDDATA:   stateNext_s = READ_BIT;
            CMD_STOP:     stateNext_s = STOP;
            CMD_PRESTART: stateNext_s = PRE_START;
            default:      stateNext_s = IDLE;
          endcase
        end else begin
          stateNext_s = IDLE;
        end
      end
      START, STOP, PRE_START, ACK_BIT: begin
        if (lastTick_s) stateNext_s = DONE;
        else            stateNext_s = state_r;
      end
      WRITE_BIT, READ_BIT: begin
        if (lastTick_s && (bitCnt_r == 3'd7)) stateNext_s = ACK_BIT;
        else                                  stateNext_s = state_r;
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Output logic: next bus drive levels; lines hold their level unless a phase sets them.
  always_comb begin
    sclRelNext_s = sclRel_r;
    sdaRelNext_s = sdaRel_r;
    doneNext_s   = (stateNext_s == IDLE);
    case (state_r)
      START: begin
        case (phase_r)
          3'd0:    sdaRelNext_s = 1'b1;
          3'd1:    sclRelNext_s = 1'b1;
          3'd2:    sdaRelNext_s = 1'b0;
          default: sclRelNext_s = 1'b0;
        endcase
      end
      WRITE_BIT, READ_BIT: begin
        case (phase_r)
          3'd0:    sclRelNext_s = 1'b0;
          3'd1: begin
            if (state_r == READ_BIT) sdaRelNext_s = 1'b1;
            else                     sdaRelNext_s = txByte_r[3'd7 - bitCnt_r];
          end
          default: sclRelNext_s = 1'b1;
        endcase
      end
      ACK_BIT: begin
        case (phase_r)
          3'd0:       sclRelNext_s = 1'b0;
          3'd1:       sdaRelNext_s = isRead_r ? setAck_r : 1'b1;
          3'd2, 3'd3: sclRelNext_s = 1'b1;
          default: begin
            // Hold SCL low one quarter, then let go of a master-driven ACK.
            sclRelNext_s = 1'b0;
            if (tick_s) sdaRelNext_s = 1'b1;
            else        sdaRelNext_s = sdaRel_r;
          end
        endcase
      end
      STOP: begin
        case (phase_r)
          3'd0:    begin sclRelNext_s = 1'b0; sdaRelNext_s = 1'b0; end
          3'd1:    sclRelNext_s = 1'b1;
          default: sdaRelNext_s = 1'b1;
        endcase
      end
      PRE_START: begin
        case (phase_r)
          3'd0:    sdaRelNext_s = 1'b1;
          default: sclRelNext_s = 1'b1;
        endcase
      end
      default: begin
        sclRelNext_s = sclRel_r;
        sdaRelNext_s = sdaRel_r;
      end
    endcase
  end

  // Registered bus drives and done flag.
  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      sclRel_r <= 1'b1;
      sdaRel_r <= 1'b1;
      done_r   <= 1'b1;
    end else begin
      sclRel_r <= sclRelNext_s;
      sdaRel_r <= sdaRelNext_s;
      done_r   <= doneNext_s;
    end
  end

  // Quarter timer, phase/bit counters, command capture and received data.
  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      qCnt_r   <= '0;
      phase_r  <= 3'd0;
      bitCnt_r <= 3'd0;
      txByte_r <= 8'h00;
      rxByte_r <= 8'h00;
      setAck_r <= 1'b1;
      isRead_r <= 1'b0;
      getAck_r <= 1'b0;
    end else begin
      // The timer sits at zero while a released SCL is still held low.
      if (!active_s || tick_s || (waitHigh_s && !sclHigh_s)) qCnt_r <= '0;
      else                                                   qCnt_r <= qCnt_r + QW'(1);

      if (!active_s || lastTick_s) phase_r <= 3'd0;
      else if (tick_s)             phase_r <= phase_r + 3'd1;

      if (accept_s) begin
        bitCnt_r <= 3'd0;
        txByte_r <= i_TxByte;
        setAck_r <= i_SetAck;
        isRead_r <= (i_Cmd == CMD_RDDATA);
      end else if (((state_r == WRITE_BIT) || (state_r == READ_BIT)) && lastTick_s) begin
        bitCnt_r <= bitCnt_r + 3'd1;
      end

      // Data and ACK are sampled at the middle of the SCL high time.
      if ((state_r == READ_BIT) && tick_s && (phase_r == 3'd2)) begin
        rxByte_r <= {rxByte_r[6:0], sdaIn_s};
      end
      if ((state_r == ACK_BIT) && !isRead_r && tick_s && (phase_r == 3'd2)) begin
        getAck_r <= sdaIn_s;
      end
    end
  end

endmodule

// File: tb/tb_iic_mst.sv
// tb_iic_mst -- directed bench for iic_mst with a small behavioural I2C slave.
// Q = 4000/(4*100) = 10 system clocks.
module tb_iic_mst;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       ResetN, CmdValid, SetAck;
  logic [3:0] Cmd;
  logic [7:0] TxByte;
  logic [7:0] RxByte;
  logic       Done, GetAck;
  logic       slaveSclLow, slaveSdaLow;
  wire        sclLine, sdaLine;

  pullup (sclLine);
  pullup (sdaLine);
  assign sclLine = slaveSclLow ? 1'b0 : 1'bz;
  assign sdaLine = slaveSdaLow ? 1'b0 : 1'bz;

  iic_mst #(.SYS_CLOCK(4000), .IIC_CLOCK(100)) dut (
    .i_SysClock(clk),
    .i_ResetN  (ResetN),
    .i_CmdValid(CmdValid),
    .i_Cmd     (Cmd),
    .i_TxByte  (TxByte),
    .o_RxByte  (RxByte),
    .o_Done    (Done),
    .io_SCL    (sclLine),
    .io_SDA    (sdaLine),
    .o_GetAck  (GetAck),
    .i_SetAck  (SetAck)
  );

  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;
  int startCnt = 0;
  int stopCnt  = 0;
  logic prevScl = 1'b1;
  logic prevSda = 1'b1;
  logic [7:0] slvBits;
  logic ackSeen;
  int highCnt;
  int startBase, stopBase;

  // START/STOP detector: SDA edge while SCL stays high.
  always @(posedge clk) begin
    if (prevScl && sclLine && prevSda && !sdaLine) startCnt <= startCnt + 1;
    if (prevScl && sclLine && !prevSda && sdaLine) stopCnt  <= stopCnt + 1;
    prevScl <= sclLine;
    prevSda <= sdaLine;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic waitScl(input logic lvl);
    int n;
    n = 0;
    while ((sclLine !== lvl) && (n < 20000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) checkVal("sclWaitTimeout", 32'd0, 32'd1);
  endtask

  task automatic pulseCmd(input logic [3:0] c, input logic [7:0] tx, input logic ack);
    Cmd      = c;
    TxByte   = tx;
    SetAck   = ack;
    CmdValid = 1'b1;
    @(negedge clk);
    CmdValid = 1'b0;
  endtask

  task automatic runCmd(input logic [3:0] c, input logic [7:0] tx, input logic ack);
    int n;
    pulseCmd(c, tx, ack);
    checkVal("busyAfterAccept", {31'd0, Done}, 32'd0);
    n = 0;
    while ((Done !== 1'b1) && (n < 20000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) checkVal("doneTimeout", 32'd0, 32'd1);
  endtask

  // Slave transmitter: presents bits while SCL is low, records SDA at the 9th rise.
  task automatic slaveSend(input logic [7:0] data);
    for (int i = 7; i >= 0; i--) begin
      waitScl(1'b0);
      slaveSdaLow = ~data[i];
      waitScl(1'b1);
    end
    waitScl(1'b0);
    slaveSdaLow = 1'b0;
    waitScl(1'b1);
    ackSeen = sdaLine;
    waitScl(1'b0);
  endtask

  // Slave receiver: samples on SCL rises, optionally stretches one bit, then ACK/NACK.
  task automatic slaveRecv(input logic ack, input int stretchIdx);
    int hc;
    slvBits = 8'h00;
    highCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == stretchIdx) begin
        waitScl(1'b0);
        slaveSclLow = 1'b1;
        repeat (500) @(negedge clk);
        slaveSclLow = 1'b0;
      end
      waitScl(1'b1);
      slvBits = {slvBits[6:0], sdaLine};
      hc = 0;
      while ((sclLine === 1'b1) && (hc < 5000)) begin
        @(negedge clk);
        hc++;
      end
      if (i == stretchIdx) highCnt = hc;
    end
    slaveSdaLow = (ack == 1'b0);
    waitScl(1'b1);
    waitScl(1'b0);
    slaveSdaLow = 1'b0;
  endtask

  initial begin
    ResetN = 1'b0; CmdValid = 1'b0; Cmd = 4'd0; TxByte = 8'h00; SetAck = 1'b1;
    slaveSclLow = 1'b0; slaveSdaLow = 1'b0; ackSeen = 1'b0; slvBits = 8'h00; highCnt = 0;
    repeat (5) @(negedge clk);
    checkVal("rstDone",   {31'd0, Done},    32'd1);
    checkVal("rstRxByte", {24'd0, RxByte},  32'd0);
    checkVal("rstGetAck", {31'd0, GetAck},  32'd0);
    checkVal("rstScl",    {31'd0, sclLine}, 32'd1);
    checkVal("rstSda",    {31'd0, sdaLine}, 32'd1);
    ResetN = 1'b1;
    repeat (3) @(negedge clk);

    // No-op codes keep the engine idle and the bus untouched.
    pulseCmd(4'd0, 8'h00, 1'b1);
    checkVal("nullDone", {31'd0, Done}, 32'd1);
    pulseCmd(4'd9, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    checkVal("code9Done", {31'd0, Done},    32'd1);
    checkVal("code9Scl",  {31'd0, sclLine}, 32'd1);

    // START then RDDATA with NACK, slave sends 0xA5.
    startBase = startCnt;
    runCmd(4'd1, 8'h00, 1'b1);
    checkVal("startSeen",  startCnt - startBase, 32'd1);
    checkVal("startSclLo", {31'd0, sclLine},     32'd0);
    fork
      runCmd(4'd3, 8'h00, 1'b1);
      slaveSend(8'hA5);
    join
    checkVal("rdA5Byte", {24'd0, RxByte},  32'hA5);
    checkVal("rdA5Nack", {31'd0, ackSeen}, 32'd1);
    checkVal("rdA5Done", {31'd0, Done},    32'd1);

    // RDDATA with ACK, slave sends 0x3C, then STOP.
    fork
      runCmd(4'd3, 8'h00, 1'b0);
      slaveSend(8'h3C);
    join
    checkVal("rd3CByte",   {24'd0, RxByte},  32'h3C);
    checkVal("rd3CAck",    {31'd0, ackSeen}, 32'd0);
    checkVal("rdAckRelSda", {31'd0, sdaLine}, 32'd1);
    stopBase = stopCnt;
    runCmd(4'd4, 8'h00, 1'b1);
    checkVal("stopSeen", stopCnt - stopBase, 32'd1);
    checkVal("stopScl",  {31'd0, sclLine},   32'd1);
    checkVal("stopSda",  {31'd0, sdaLine},   32'd1);

    // START, WRDATA 0x81 with ACK.
    runCmd(4'd1, 8'h00, 1'b1);
    fork
      runCmd(4'd2, 8'h81, 1'b1);
      slaveRecv(1'b0, 8);
    join
    checkVal("wr81Bits", {24'd0, slvBits}, 32'h81);
    checkVal("wr81Ack",  {31'd0, GetAck},  32'd0);

    // WRDATA 0x5E with NACK.
    fork
      runCmd(4'd2, 8'h5E, 1'b1);
      slaveRecv(1'b1, 8);
    join
    checkVal("wr5EBits", {24'd0, slvBits}, 32'h5E);
    checkVal("wr5ENack", {31'd0, GetAck},  32'd1);
    checkVal("wr5EDone", {31'd0, Done},    32'd1);

    // WRDATA 0xC3 with the slave stretching bit 3 for 500 cycles.
    fork
      runCmd(4'd2, 8'hC3, 1'b1);
      slaveRecv(1'b0, 3);
    join
    checkVal("stretchBits", {24'd0, slvBits},                 32'hC3);
    checkVal("stretchHigh", {31'd0, (highCnt >= (2 * Q))},    32'd1);
    checkVal("stretchAck",  {31'd0, GetAck},                  32'd0);

    // PRE_START: releases both lines without a START or STOP condition.
    startBase = startCnt;
    stopBase  = stopCnt;
    runCmd(4'd5, 8'h00, 1'b1);
    checkVal("preScl",     {31'd0, sclLine},     32'd1);
    checkVal("preSda",     {31'd0, sdaLine},     32'd1);
    checkVal("preNoStart", startCnt - startBase, 32'd0);
    checkVal("preNoStop",  stopCnt - stopBase,   32'd0);

    // Reset in the middle of WRDATA 0x00.
    runCmd(4'd1, 8'h00, 1'b1);
    pulseCmd(4'd2, 8'h00, 1'b1);
    repeat (100) @(negedge clk);
    checkVal("midWrSdaLo", {31'd0, sdaLine}, 32'd0);
    ResetN = 1'b0;
    @(negedge clk);
    checkVal("abortScl",    {31'd0, sclLine}, 32'd1);
    checkVal("abortSda",    {31'd0, sdaLine}, 32'd1);
    checkVal("abortDone",   {31'd0, Done},    32'd1);
    checkVal("abortRxByte", {24'd0, RxByte},  32'd0);
    ResetN = 1'b1;
    startBase = startCnt;
    repeat (200) @(negedge clk);
    checkVal("quietScl",   {31'd0, sclLine},     32'd1);
    checkVal("quietSda",   {31'd0, sdaLine},     32'd1);
    checkVal("quietStart", startCnt - startBase, 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
